spi_target: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_target_if.sv | 17 +
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_target.sv | 144 ++++++++++++++
 tb/tb_spi_target.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target.
//   state_t      : target FSM states (IDLE, SHIFT, HOLD)
//   SPI_DATA_W   : default frame length in bits
//   SYNC_STAGES  : flop count of each input synchronizer (excluding the delay flop)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int SPI_DATA_W  = 16;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_target_if.sv
// SPI bus pins between a master and this target.
//   sclk, cs_l, mosi : driven by the master
//   miso, miso_oe    : driven by the target
//   modport master   : master side of the bus
//   modport slave    : target side of the bus
interface spi_target_if;

    logic sclk;
    logic cs_l;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs_l, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs_l, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Input synchronizer with edge detection for one asynchronous pin.
// A SYNC_STAGES-deep flop chain brings the pin into the clk domain; a
// further delay flop holds the previous synchronized level so rise/fall
// strobes are single-cycle and combinational from flops only.
//   clk, reset : system clock, async active-low reset
//   din        : raw asynchronous pin
//   dout       : synchronized level
//   rise, fall : one-cycle strobes on synchronized transitions
//   RST_VAL    : idle level of the pin, loaded on reset so no false edge
//                is seen when reset releases on an idle bus
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            dly   <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise =  dout & ~dly;
    assign fall = ~dout &  dly;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target. Oversamples the bus on clk, receives one DATA_W-bit
// frame per chip-select window and returns a word captured at frame start.
//   clk, reset : system clock, async active-low reset
//   bus        : SPI pins (slave modport): sclk, cs_l, mosi in; miso, miso_oe out
//   tx_data    : response word, sampled on the cs_l fall strobe only
//   rx_data    : last complete received word, held until the next one
//   rx_valid   : one-cycle pulse when rx_data updates
//   frame_err  : one-cycle pulse when cs_l rises before a full frame
//   busy       : high from frame start until cs_l release
// Build option: define SPI_TARGET_LSB_FIRST_EN for LSB-first shifting in
// both directions; default is MSB first.
module spi_target
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    spi_target_if.slave       bus,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int               CNT_W   = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

    // Synchronized pins and edge strobes
    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(bus.sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(bus.cs_l),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(bus.mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // The last received bit goes straight into rx_data, so the receive
    // register only ever holds DATA_W-1 bits.
    state_t            state, state_nx;
    logic [DATA_W-1:0] tx_sr, tx_nx;
    logic [DATA_W-2:0] rx_sr, rx_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DATA_W-1:0] rx_data_nx;
    logic              rx_valid_nx, frame_err_nx;
    logic [DATA_W-1:0] rx_shift, tx_shift;
    logic              tx_bit;

`ifdef SPI_TARGET_LSB_FIRST_EN
    assign rx_shift = {mosi_s, rx_sr};
    assign tx_shift = {1'b0, tx_sr[DATA_W-1:1]};
    assign tx_bit   = tx_sr[0];
`else
    assign rx_shift = {rx_sr, mosi_s};
    assign tx_shift = {tx_sr[DATA_W-2:0], 1'b0};
    assign tx_bit   = tx_sr[DATA_W-1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cnt       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            tx_sr     <= tx_nx;
            rx_sr     <= rx_nx;
            cnt       <= cnt_nx;
            rx_data   <= rx_data_nx;
            rx_valid  <= rx_valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        tx_nx        = tx_sr;
        rx_nx        = rx_sr;
        cnt_nx       = cnt;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    tx_nx    = tx_data;
                    rx_nx    = '0;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // Chip-select release takes priority over a coincident
                // sclk rise: the bit is dropped and the frame is short.
                if (cs_rise) begin
                    if (cnt < CNT_MAX)
                        frame_err_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_nx  = rx_shift[DATA_W-2:0];
`ifdef SPI_TARGET_LSB_FIRST_EN
                        rx_nx  = rx_shift[DATA_W-1:1];
`endif
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt_nx == CNT_MAX) begin
                            rx_data_nx  = rx_shift;
                            rx_valid_nx = 1'b1;
                            state_nx    = HOLD;
                        end
                    end
                    if (sclk_fall)
                        tx_nx = tx_shift;
                end
            end
            HOLD: begin
                if (cs_rise)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.miso    = (state == SHIFT) ? tx_bit : 1'b0;
    assign bus.miso_oe = (state != IDLE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target. A bus-master task drives mode-0
// frames; received words are checked against a scoreboard queue filled
// when each full frame is sent, and miso is checked by the master.
module tb_spi_target;
    import spi_pkg::*;

    localparam int W = SPI_DATA_W;
`ifdef SPI_TARGET_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic [W-1:0] rx_data;
    logic         rx_valid, frame_err, busy;

    spi_target_if bus();

    spi_target #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .tx_data(tx_data), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    int           val_cnt = 0;
    int           err_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;
    logic [W-1:0] got;
    int           extra_bad;
    bit           mid_ok;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rx_valid) begin
            val_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: rx_valid with rx_data=%h, no word queued", rx_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (rx_data !== sb_exp) begin
                    fails++;
                    $display("FAIL sb_rx_data: got %h, expected %h", rx_data, sb_exp);
                end
            end
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Mode-0 master: mosi changes with sclk low, miso sampled before each rise.
    task automatic send_frame(input logic [W-1:0] word, input logic [W-1:0] tx,
                              input int nbits, input bit release_cs);
        tx_data = tx;
        @(negedge clk);
        bus.cs_l = 1'b0;
        repeat (6) @(negedge clk);
        tx_data = ~tx;   // must not affect the frame in flight
        got = '0;
        extra_bad = 0;
        mid_ok = (busy === 1'b1) && (bus.miso_oe === 1'b1);
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = LSB ? i : W - 1 - i;
            bus.mosi = (i < W) ? word[idx] : 1'b1;
            repeat (4) @(negedge clk);
            if (i < W) got[idx] = bus.miso;
            else if (bus.miso !== 1'b0) extra_bad++;
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (release_cs) begin
            bus.cs_l = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        bus.cs_l = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({bus.miso, bus.miso_oe, rx_data, rx_valid, frame_err, busy} !== '0) begin
            fails++;
            $display("FAIL reset_hold: outputs %h, expected 0",
                     {bus.miso, bus.miso_oe, rx_data, rx_valid, frame_err, busy});
        end
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({bus.miso, bus.miso_oe, rx_data, rx_valid, frame_err, busy} !== '0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_idle: %0d cycles with nonzero outputs, expected 0", bad);
        end
    endtask

    task automatic test_frame();
        int v0;
        v0 = val_cnt;
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 16'h3C5A, W, 1'b1);
        tests++;
        if (got !== 16'h3C5A) begin
            fails++;
            $display("FAIL frame_miso: got %h, expected %h", got, 16'h3C5A);
        end
        tests++;
        if (rx_data !== 16'hA5C3) begin
            fails++;
            $display("FAIL frame_rx_data: got %h, expected %h", rx_data, 16'hA5C3);
        end
        tests++;
        if (val_cnt - v0 !== 1) begin
            fails++;
            $display("FAIL frame_rx_valid_count: got %0d, expected 1", val_cnt - v0);
        end
        tests++;
        if (!mid_ok) begin
            fails++;
            $display("FAIL frame_busy_oe: busy/miso_oe low during frame, expected high");
        end
        tests++;
        if ({busy, bus.miso_oe} !== 2'b00) begin
            fails++;
            $display("FAIL frame_release: busy/miso_oe=%b, expected 00", {busy, bus.miso_oe});
        end
    endtask

    task automatic test_abort();
        int v0, e0;
        v0 = val_cnt;
        e0 = err_cnt;
        send_frame(16'h5555, 16'h0000, 9, 1'b1);
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL abort_frame_err: got %0d pulses, expected 1", err_cnt - e0);
        end
        tests++;
        if (val_cnt - v0 !== 0) begin
            fails++;
            $display("FAIL abort_rx_valid: got %0d pulses, expected 0", val_cnt - v0);
        end
        tests++;
        if (rx_data !== 16'hA5C3) begin
            fails++;
            $display("FAIL abort_rx_hold: got %h, expected %h", rx_data, 16'hA5C3);
        end
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 16'hBEEF, W, 1'b1);
        tests++;
        if (rx_data !== 16'h1234 || got !== 16'hBEEF) begin
            fails++;
            $display("FAIL abort_next: rx %h miso %h, expected 1234 beef", rx_data, got);
        end
    endtask

    task automatic test_overrun();
        int v0, e0;
        v0 = val_cnt;
        e0 = err_cnt;
        exp_q.push_back(16'hFFFF);
        send_frame(16'hFFFF, 16'h0F0F, W + 2, 1'b1);
        tests++;
        if (rx_data !== 16'hFFFF) begin
            fails++;
            $display("FAIL overrun_rx_data: got %h, expected ffff", rx_data);
        end
        tests++;
        if (val_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL overrun_pulses: rx_valid %0d frame_err %0d, expected 1 0",
                     val_cnt - v0, err_cnt - e0);
        end
        tests++;
        if (extra_bad !== 0 || got !== 16'h0F0F) begin
            fails++;
            $display("FAIL overrun_miso: %0d extra bits nonzero, miso word %h, expected 0 0f0f",
                     extra_bad, got);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        send_frame(16'h8001, 16'h6666, 5, 1'b0);
        v0 = val_cnt;
        e0 = err_cnt;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({busy, bus.miso_oe, bus.miso, rx_data} !== '0) begin
            fails++;
            $display("FAIL midreset_clear: busy/oe/miso/rx=%h, expected 0",
                     {busy, bus.miso_oe, bus.miso, rx_data});
        end
        bus.cs_l = 1'b1;
        bus.sclk = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (val_cnt - v0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: rx_valid %0d frame_err %0d busy %b, expected 0 0 0",
                     val_cnt - v0, err_cnt - e0, busy);
        end
        exp_q.push_back(16'h8001);
        send_frame(16'h8001, 16'h6666, W, 1'b1);
        tests++;
        if (rx_data !== 16'h8001 || got !== 16'h6666) begin
            fails++;
            $display("FAIL midreset_next: rx %h miso %h, expected 8001 6666", rx_data, got);
        end
    endtask

`ifdef SPI_TARGET_LSB_FIRST_EN
    task automatic test_lsb_first();
        exp_q.push_back(16'h0001);
        send_frame(16'h0001, 16'h8000, W, 1'b1);
        tests++;
        if (rx_data !== 16'h0001) begin
            fails++;
            $display("FAIL lsb_rx_data: got %h, expected 0001", rx_data);
        end
        tests++;
        if (got[0] !== 1'b0 || got[W-1] !== 1'b1) begin
            fails++;
            $display("FAIL lsb_miso: first %b last %b, expected 0 1", got[0], got[W-1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_abort();
        test_overrun();
        test_reset_midframe();
`ifdef SPI_TARGET_LSB_FIRST_EN
        test_lsb_first();
`endif
        repeat (10) @(negedge clk);
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL sb_drain: %0d words never received, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
